// File: rtl/gc_proto_pkg.sv
// Shared constants and FSM encoding for the GameCube poll-response receiver.
// Tick values assume the 27 MHz system clock (1 us = 27 ticks).
package gc_proto_pkg;

    localparam int US_TICKS         = 27;
    localparam int SAMPLE_TICKS_DEF = 2 * US_TICKS;
    localparam int MAXLOW_TICKS_DEF = 5 * US_TICKS;
    localparam int BITGAP_TICKS_DEF = 6 * US_TICKS;
    localparam int RESP_TIMEOUT_DEF = 100 * US_TICKS;

    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = 12;
    localparam int IDX_W      = 7;

    // Field LSB positions inside the 64-bit frame (MSB = first bit on the wire)
    localparam int BTN_LSB = 48;
    localparam int JX_LSB  = 40;
    localparam int JY_LSB  = 32;
    localparam int CX_LSB  = 24;
    localparam int CY_LSB  = 16;
    localparam int TL_LSB  = 8;
    localparam int TR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_WAIT_REL
    } rx_state_t;

endpackage

// File: rtl/gc_line_sync.sv
// 2-flop synchronizer for the GC data line plus a falling-edge pulse.
// Ports: clk, reset (async, active-high), din (raw pin), line (sync level), fall.
module gc_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    // All stages reset to the idle-high level so reset never fakes an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign line = s2;
    assign fall = prev & ~s2;

endmodule

// File: rtl/gc_response_rx.sv
// Decodes the controller's 64-bit pulse-width poll response plus stop bit.
// Ports: clk, reset, GC_data, GC_enable in; frame, decoded fields,
// frame_valid / frame_error strobes and rx_busy out.
module gc_response_rx
    import gc_proto_pkg::*;
#(
    parameter int SAMPLE_TICKS = SAMPLE_TICKS_DEF,
    parameter int MAXLOW_TICKS = MAXLOW_TICKS_DEF,
    parameter int BITGAP_TICKS = BITGAP_TICKS_DEF,
    parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        GC_data,
    input  logic        GC_enable,
    output logic [63:0] frame,
    output logic [15:0] buttons,
    output logic [7:0]  joy_x,
    output logic [7:0]  joy_y,
    output logic [7:0]  cstick_x,
    output logic [7:0]  cstick_y,
    output logic [7:0]  trig_l,
    output logic [7:0]  trig_r,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        rx_busy
);

    localparam logic [CNT_W-1:0] SAMPLE_T = CNT_W'(SAMPLE_TICKS);
    localparam logic [CNT_W-1:0] MAXLOW_T = CNT_W'(MAXLOW_TICKS);
    localparam logic [CNT_W-1:0] BITGAP_T = CNT_W'(BITGAP_TICKS);
    localparam logic [CNT_W-1:0] RESP_T   = CNT_W'(RESP_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS);

    logic             line;
    logic             fall;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [63:0]      shreg;
    logic             commit;

    gc_line_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (GC_data),
        .line  (line),
        .fall  (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            commit      <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            commit      <= 1'b0;

            // Load one cycle after the stop bit was accepted
            if (commit) begin
                frame       <= shreg;
                frame_valid <= 1'b1;
            end

            // Counter runs from the last falling edge and saturates
            if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    idx   <= '0;
                    shreg <= '0;
                    if (!GC_enable) begin
                        state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (GC_enable) begin
                        state <= ST_IDLE;
                    end else if (fall) begin
                        state <= ST_BIT_LOW;
                        cnt   <= '0;
                    end else if (cnt == RESP_T) begin
                        frame_error <= 1'b1;
                        state       <= ST_WAIT_REL;
                    end
                end

                ST_BIT_LOW: begin
                    if (GC_enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        shreg <= '0;
                    end else if (cnt == SAMPLE_T) begin
                        if (idx < LAST_IDX) begin
                            shreg <= {shreg[62:0], line};
                            idx   <= idx + 1'b1;
                            state <= ST_BIT_HIGH;
                        end else begin
                            // Stop bit must read high
                            if (line) begin
                                commit <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                            state <= ST_WAIT_REL;
                        end
                    end else if (!line && cnt == MAXLOW_T) begin
                        frame_error <= 1'b1;
                        state       <= ST_WAIT_REL;
                    end
                end

                ST_BIT_HIGH: begin
                    if (GC_enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        shreg <= '0;
                    end else if (fall) begin
                        state <= ST_BIT_LOW;
                        cnt   <= '0;
                    end else if (!line && cnt == MAXLOW_T) begin
                        // Low pulse still running after the sample point
                        frame_error <= 1'b1;
                        state       <= ST_WAIT_REL;
                    end else if (cnt == BITGAP_T) begin
                        frame_error <= 1'b1;
                        state       <= ST_WAIT_REL;
                    end
                end

                ST_WAIT_REL: begin
                    if (GC_enable) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_busy  = (state != ST_IDLE);
    assign buttons  = frame[BTN_LSB +: 16];
    assign joy_x    = frame[JX_LSB +: 8];
    assign joy_y    = frame[JY_LSB +: 8];
    assign cstick_x = frame[CX_LSB +: 8];
    assign cstick_y = frame[CY_LSB +: 8];
    assign trig_l   = frame[TL_LSB +: 8];
    assign trig_r   = frame[TR_LSB +: 8];

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed bench for gc_response_rx: frame vectors plus error/abort cases.
// Bits are driven at 4 us (108 ticks): '1' = 1 us low, '0' = 3 us low.
`timescale 1ns/1ps
module tb_gc_response_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        GC_data;
    logic        GC_enable;
    logic [63:0] frame;
    logic [15:0] buttons;
    logic [7:0]  joy_x;
    logic [7:0]  joy_y;
    logic [7:0]  cstick_x;
    logic [7:0]  cstick_y;
    logic [7:0]  trig_l;
    logic [7:0]  trig_r;
    logic        frame_valid;
    logic        frame_error;
    logic        rx_busy;

    gc_response_rx dut (
        .clk         (clk),
        .reset       (reset),
        .GC_data     (GC_data),
        .GC_enable   (GC_enable),
        .frame       (frame),
        .buttons     (buttons),
        .joy_x       (joy_x),
        .joy_y       (joy_y),
        .cstick_x    (cstick_x),
        .cstick_y    (cstick_y),
        .trig_l      (trig_l),
        .trig_r      (trig_r),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int nvalid = 0;
    int nerror = 0;
    int nboth  = 0;
    int vcyc   = 0;
    int ecyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            nvalid <= nvalid + 1;
            vcyc   <= cyc;
        end
        if (frame_error) begin
            nerror <= nerror + 1;
            ecyc   <= cyc;
        end
        if (frame_valid && frame_error) nboth <= nboth + 1;
    end

    int total = 0;
    int bad   = 0;
    int last_fall = 0;

    typedef struct {
        logic [63:0] data;
        bit          jit;
        logic [15:0] btn;
        logic [7:0]  jx;
        logic [7:0]  jy;
        logic [7:0]  cx;
        logic [7:0]  cy;
        logic [7:0]  tl;
        logic [7:0]  tr;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act,
                               input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int jit);
        int lo;
        lo = (b ? 27 : 81) + jit;
        GC_data = 1'b0;
        last_fall = cyc;
        ticks(lo);
        GC_data = 1'b1;
        ticks(108 - lo);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n, input bit jit);
        for (int i = 0; i < n; i++) begin
            send_bit(d[63-i], jit ? ((i % 2 != 0) ? 5 : -5) : 0);
        end
    endtask

    task automatic arm();
        GC_enable = 1'b1;
        ticks(4);
        GC_enable = 1'b0;
        ticks(4);
    endtask

    task automatic release_line();
        GC_enable = 1'b1;
        ticks(4);
    endtask

    task automatic wait_error(input int bound, output bit ok);
        int e0;
        e0 = nerror;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            ticks(1);
            #1;
            if (nerror != e0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int v0;
        int e0;
        int stop_fall;
        bit ok;
        logic [63:0] keep;

        vecs[0] = '{64'h0080_8080_8080_0000, 1'b0, 16'h0080,
                    8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
        vecs[1] = '{64'hAAAA_5555_F00F_0FF0, 1'b1, 16'hAAAA,
                    8'h55, 8'h55, 8'hF0, 8'h0F, 8'h0F, 8'hF0};
        vecs[2] = '{64'h1234_0102_FE7F_C03D, 1'b1, 16'h1234,
                    8'h01, 8'h02, 8'hFE, 8'h7F, 8'hC0, 8'h3D};

        reset     = 1'b1;
        GC_data   = 1'b1;
        GC_enable = 1'b1;
        ticks(3);
        #1;
        check("rst_frame", frame, 64'h0);
        check("rst_buttons", buttons, 16'h0);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_error", frame_error, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        ticks(1);
        reset = 1'b0;
        ticks(3);

        for (int v = 0; v < 3; v++) begin
            v0 = nvalid;
            e0 = nerror;
            arm();
            send_bits(vecs[v].data, 64, vecs[v].jit);
            send_bit(1'b1, 0);
            stop_fall = last_fall;
            release_line();
            check("vec_valid_cnt", 64'(nvalid - v0), 64'd1);
            check("vec_error_cnt", 64'(nerror - e0), 64'd0);
            check("vec_frame", frame, vecs[v].data);
            check("vec_buttons", buttons, vecs[v].btn);
            check("vec_joy_x", joy_x, vecs[v].jx);
            check("vec_joy_y", joy_y, vecs[v].jy);
            check("vec_cstick_x", cstick_x, vecs[v].cx);
            check("vec_cstick_y", cstick_y, vecs[v].cy);
            check("vec_trig_l", trig_l, vecs[v].tl);
            check("vec_trig_r", trig_r, vecs[v].tr);
            // 3 sync cycles from pin, then 55..56 to the commit strobe
            check_range("vec_latency", vcyc - stop_fall, 58, 59);
        end

        // Short frame: 32 bits, then the line stays high
        keep = frame;
        v0 = nvalid;
        arm();
        send_bits(64'hFFFF_0000_1234_5678, 32, 1'b0);
        wait_error(300, ok);
        check("short_err_seen", ok, 1'b1);
        check_range("short_err_time", ecyc - last_fall, 165, 166);
        check("short_no_valid", 64'(nvalid - v0), 64'd0);
        check("short_frame_kept", frame, keep);
        release_line();

        // Response timeout, single error until GC_enable toggles
        e0 = nerror;
        GC_enable = 1'b1;
        ticks(4);
        GC_enable = 1'b0;
        wait_error(2800, ok);
        check("tmo_err_seen", ok, 1'b1);
        ticks(3000);
        #1;
        check("tmo_single", 64'(nerror - e0), 64'd1);
        check("tmo_busy_wait", rx_busy, 1'b1);
        GC_enable = 1'b1;
        ticks(4);
        GC_enable = 1'b0;
        wait_error(2800, ok);
        check("tmo_rearm_err", ok, 1'b1);
        release_line();

        // Silent abort after 20 bits, then a clean frame
        v0 = nvalid;
        e0 = nerror;
        arm();
        send_bits(64'hC3C3_3C3C_A5A5_5A5A, 20, 1'b0);
        GC_enable = 1'b1;
        ticks(3);
        #1;
        check("abort_idle", rx_busy, 1'b0);
        ticks(200);
        check("abort_no_valid", 64'(nvalid - v0), 64'd0);
        check("abort_no_error", 64'(nerror - e0), 64'd0);
        arm();
        send_bits(64'hDEAD_BEEF_0123_4567, 64, 1'b0);
        send_bit(1'b1, 0);
        release_line();
        check("post_abort_frame", frame, 64'hDEAD_BEEF_0123_4567);
        check("post_abort_valid", 64'(nvalid - v0), 64'd1);

        // Line held low for 6 us during bit 5
        keep = frame;
        v0 = nvalid;
        e0 = nerror;
        arm();
        send_bits(64'h0, 5, 1'b0);
        GC_data = 1'b0;
        ticks(162);
        GC_data = 1'b1;
        ticks(20);
        check("low_err_cnt", 64'(nerror - e0), 64'd1);
        check("low_no_valid", 64'(nvalid - v0), 64'd0);
        check("low_frame_kept", frame, keep);
        release_line();

        // Reset in the middle of a frame
        arm();
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0);
        GC_data = 1'b0;
        ticks(5);
        reset = 1'b1;
        ticks(1);
        #1;
        check("rstmid_frame", frame, 64'h0);
        check("rstmid_joy_x", joy_x, 8'h0);
        check("rstmid_busy", rx_busy, 1'b0);
        check("rstmid_valid", frame_valid, 1'b0);
        check("rstmid_error", frame_error, 1'b0);
        GC_data = 1'b1;
        ticks(2);
        reset = 1'b0;
        release_line();

        check("never_both", 64'(nboth), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
